// File: rtl/actor_pkg.sv
// rtl/actor_pkg.sv - shared types and constants for dataflow actors
//
// Contents:
//   DATA_W        token width on every actor stream
//   actor_state_t firing state shared by the actors of the fabric

package actor_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } actor_state_t;

endpackage

// File: rtl/actor_rate_counter.sv
// rtl/actor_rate_counter.sv - per-input token counter for one SDF firing
//
// Counts tokens accepted on one input during the current firing.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   fire        a token was accepted this cycle (only asserted while ready)
//   clear       firing completed; count returns to zero (wins over fire)
//   done        count == RATE
//   ready       count <  RATE
//   last        count == RATE-1, so one more accepted token completes the rate

module actor_rate_counter #(
    parameter int RATE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fire,
    input  logic clear,
    output logic done,
    output logic ready,
    output logic last
);

    localparam int CW = $clog2(RATE + 1);
    localparam logic [CW-1:0] RATE_V = CW'(RATE);
    localparam logic [CW-1:0] LAST_V = CW'(RATE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (fire) begin
            count <= count + 1'b1;
        end
    end

    assign done  = (count == RATE_V);
    assign ready = (count <  RATE_V);
    assign last  = (count == LAST_V);

endmodule

// File: rtl/actor_misotoken.sv
// rtl/actor_misotoken.sv - two-input one-output SDF summing actor
//
// Each firing takes RATE0 tokens from s0 and RATE1 tokens from s1 and emits
// their 32-bit wrap-around sum as one token on s2.
// Ports:
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   actormisotoken_s0_*             input stream 0 (data/valid/ready)
//   actormisotoken_s1_*             input stream 1 (data/valid/ready)
//   actormisotoken_s2_*             output stream (data/valid/ready)
//   fire_count                      completed firings, wraps at 2^32

module actor_misotoken
    import actor_pkg::*;
#(
    parameter int RATE0 = 2,
    parameter int RATE1 = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] actormisotoken_s0_data,
    input  logic              actormisotoken_s0_valid,
    output logic              actormisotoken_s0_ready,
    input  logic [DATA_W-1:0] actormisotoken_s1_data,
    input  logic              actormisotoken_s1_valid,
    output logic              actormisotoken_s1_ready,
    output logic [DATA_W-1:0] actormisotoken_s2_data,
    output logic              actormisotoken_s2_valid,
    input  logic              actormisotoken_s2_ready,
    output logic [31:0]       fire_count
);

    actor_state_t      state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic              done0, done1;
    logic              rdy0, rdy1;
    logic              last0, last1;
    logic              s0_fire, s1_fire;
    logic              fin0, fin1;
    logic              emit_xfer;

    // Ready depends only on state, counters and reset, never on valid/ready
    // inputs; gating with reset keeps both inputs closed while held in reset.
    assign actormisotoken_s0_ready = reset_reset_n && (state == COLLECT) && rdy0;
    assign actormisotoken_s1_ready = reset_reset_n && (state == COLLECT) && rdy1;

    assign s0_fire   = actormisotoken_s0_valid && actormisotoken_s0_ready;
    assign s1_fire   = actormisotoken_s1_valid && actormisotoken_s1_ready;
    assign emit_xfer = (state == EMIT) && actormisotoken_s2_ready;

    // Rate satisfied once this cycle's transfers are counted.
    assign fin0 = done0 || (s0_fire && last0);
    assign fin1 = done1 || (s1_fire && last1);

    assign acc_next = acc
                    + (s0_fire ? actormisotoken_s0_data : '0)
                    + (s1_fire ? actormisotoken_s1_data : '0);

    actor_rate_counter #(.RATE(RATE0)) u_cnt0 (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .fire  (s0_fire),
        .clear (emit_xfer),
        .done  (done0),
        .ready (rdy0),
        .last  (last0)
    );

    actor_rate_counter #(.RATE(RATE1)) u_cnt1 (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .fire  (s1_fire),
        .clear (emit_xfer),
        .done  (done1),
        .ready (rdy1),
        .last  (last1)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state                   <= COLLECT;
            acc                     <= '0;
            actormisotoken_s2_data  <= '0;
            actormisotoken_s2_valid <= 1'b0;
            fire_count              <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    acc <= acc_next;
                    if (fin0 && fin1) begin
                        state                   <= EMIT;
                        actormisotoken_s2_data  <= acc_next;
                        actormisotoken_s2_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    // s2_data is left holding the last sum after the handoff.
                    if (actormisotoken_s2_ready) begin
                        state                   <= COLLECT;
                        acc                     <= '0;
                        actormisotoken_s2_valid <= 1'b0;
                        fire_count              <= fire_count + 32'd1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_actor_misotoken.sv
// tb/tb_actor_misotoken.sv - self-checking bench for actor_misotoken

module tb_actor_misotoken;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] a_s0_data = '0, a_s1_data = '0, a_s2_data;
    logic        a_s0_valid = 1'b0, a_s1_valid = 1'b0, a_s2_ready = 1'b1;
    logic        a_s0_ready, a_s1_ready, a_s2_valid;
    logic [31:0] a_fire_count;

    logic [31:0] b_s0_data = '0, b_s1_data = '0, b_s2_data;
    logic        b_s0_valid = 1'b0, b_s1_valid = 1'b0, b_s2_ready = 1'b0;
    logic        b_s0_ready, b_s1_ready, b_s2_valid;
    logic [31:0] b_fire_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    actor_misotoken dut_a (
        .clk_clk                 (clk),
        .reset_reset_n           (rst_n),
        .actormisotoken_s0_data  (a_s0_data),
        .actormisotoken_s0_valid (a_s0_valid),
        .actormisotoken_s0_ready (a_s0_ready),
        .actormisotoken_s1_data  (a_s1_data),
        .actormisotoken_s1_valid (a_s1_valid),
        .actormisotoken_s1_ready (a_s1_ready),
        .actormisotoken_s2_data  (a_s2_data),
        .actormisotoken_s2_valid (a_s2_valid),
        .actormisotoken_s2_ready (a_s2_ready),
        .fire_count              (a_fire_count)
    );

    actor_misotoken #(.RATE0(1), .RATE1(4)) dut_b (
        .clk_clk                 (clk),
        .reset_reset_n           (rst_n),
        .actormisotoken_s0_data  (b_s0_data),
        .actormisotoken_s0_valid (b_s0_valid),
        .actormisotoken_s0_ready (b_s0_ready),
        .actormisotoken_s1_data  (b_s1_data),
        .actormisotoken_s1_valid (b_s1_valid),
        .actormisotoken_s1_ready (b_s1_ready),
        .actormisotoken_s2_data  (b_s2_data),
        .actormisotoken_s2_valid (b_s2_valid),
        .actormisotoken_s2_ready (b_s2_ready),
        .fire_count              (b_fire_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one token on dut_a input ch; returns just after the accepting edge.
    task automatic offer(input int ch, input logic [31:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        if (ch == 0) begin a_s0_valid = 1'b1; a_s0_data = d; end
        else         begin a_s1_valid = 1'b1; a_s1_data = d; end
        while (!acc && n < 20) begin
            acc = (ch == 0) ? a_s0_ready : a_s1_ready;
            step();
            n++;
        end
        a_s0_valid = 1'b0;
        a_s1_valid = 1'b0;
        chk("offer_accepted", {31'b0, acc}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] s0_a;
        logic [31:0] s0_b;
        logic [31:0] s1_a;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs[4];

    logic [31:0] t0[1000];
    logic [31:0] t1[4000];
    logic [31:0] exp_b[1000];

    initial begin
        vecs[0] = '{32'd3,          32'd4,   32'd10,  32'd17};
        vecs[1] = '{32'hFFFF_FFFF,  32'h2,   32'h1,   32'h0000_0002};
        vecs[2] = '{32'd100,        32'd200, 32'd300, 32'd600};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000, 32'h5, 32'h5};

        // Reset state
        step();
        chk("reset_s0_ready", {31'b0, a_s0_ready}, 32'd0);
        chk("reset_s1_ready", {31'b0, a_s1_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_reset_s0_ready", {31'b0, a_s0_ready}, 32'd1);
        chk("post_reset_s1_ready", {31'b0, a_s1_ready}, 32'd1);
        chk("post_reset_s2_valid", {31'b0, a_s2_valid}, 32'd0);
        chk("post_reset_s2_data", a_s2_data, 32'd0);
        chk("post_reset_fire_count", a_fire_count, 32'd0);

        // Table-driven firings with s2_ready held high
        a_s2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(0, vecs[i].s0_a);
            offer(0, vecs[i].s0_b);
            offer(1, vecs[i].s1_a);
            chk("vec_s2_valid", {31'b0, a_s2_valid}, 32'd1);
            chk("vec_s2_data", a_s2_data, vecs[i].sum);
            chk("vec_emit_s0_ready", {31'b0, a_s0_ready}, 32'd0);
            step();
            chk("vec_fire_count", a_fire_count, 32'(i + 1));
            chk("vec_s2_valid_drop", {31'b0, a_s2_valid}, 32'd0);
            chk("vec_collect_s0_ready", {31'b0, a_s0_ready}, 32'd1);
        end

        // Simultaneous accept, then output stall for 5 cycles
        a_s2_ready = 1'b0;
        a_s0_valid = 1'b1; a_s0_data = 32'd5;
        a_s1_valid = 1'b1; a_s1_data = 32'd7;
        step();
        chk("simul_s1_ready_low", {31'b0, a_s1_ready}, 32'd0);
        chk("simul_s0_ready_high", {31'b0, a_s0_ready}, 32'd1);
        chk("simul_s2_valid_low", {31'b0, a_s2_valid}, 32'd0);
        a_s1_valid = 1'b0;
        a_s0_data  = 32'd1;
        step();
        a_s0_valid = 1'b0;
        chk("simul_s2_valid", {31'b0, a_s2_valid}, 32'd1);
        chk("simul_s2_data", a_s2_data, 32'd13);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_s2_valid", {31'b0, a_s2_valid}, 32'd1);
            chk("stall_s2_data", a_s2_data, 32'd13);
            chk("stall_s0_ready", {31'b0, a_s0_ready}, 32'd0);
            chk("stall_s1_ready", {31'b0, a_s1_ready}, 32'd0);
        end
        chk("stall_fire_count", a_fire_count, 32'd4);
        a_s2_ready = 1'b1;
        step();
        chk("release_s2_valid", {31'b0, a_s2_valid}, 32'd0);
        chk("release_fire_count", a_fire_count, 32'd5);
        chk("release_s0_ready", {31'b0, a_s0_ready}, 32'd1);
        chk("release_s1_ready", {31'b0, a_s1_ready}, 32'd1);

        // Reset mid-firing
        offer(0, 32'd50);
        rst_n = 1'b0;
        #1;
        chk("midrst_s0_ready", {31'b0, a_s0_ready}, 32'd0);
        chk("midrst_s1_ready", {31'b0, a_s1_ready}, 32'd0);
        chk("midrst_s2_valid", {31'b0, a_s2_valid}, 32'd0);
        chk("midrst_s2_data", a_s2_data, 32'd0);
        chk("midrst_fire_count", a_fire_count, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        offer(0, 32'd1);
        offer(0, 32'd2);
        offer(1, 32'd3);
        chk("after_rst_s2_data", a_s2_data, 32'd6);
        step();
        chk("after_rst_fire_count", a_fire_count, 32'd1);

        // Reset while output pending drops s2_valid without a clock edge
        a_s2_ready = 1'b0;
        offer(0, 32'd1);
        offer(0, 32'd1);
        offer(1, 32'd1);
        chk("emit_before_rst_valid", {31'b0, a_s2_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("emit_rst_s2_valid", {31'b0, a_s2_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        a_s2_ready = 1'b1;
        #1;

        // Random firings on RATE0=1, RATE1=4 instance
        for (int i = 0; i < 1000; i++) begin
            t0[i] = $urandom;
            exp_b[i] = t0[i];
        end
        for (int i = 0; i < 4000; i++) begin
            t1[i] = $urandom;
            exp_b[i / 4] = exp_b[i / 4] + t1[i];
        end
        fork
            begin : prod0
                int cyc = 0;
                for (int i = 0; i < 1000 && cyc < 60000; i++) begin
                    logic acc;
                    b_s0_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin step(); cyc++; end
                    b_s0_valid = 1'b1;
                    b_s0_data  = t0[i];
                    acc = 1'b0;
                    while (!acc && cyc < 60000) begin
                        acc = b_s0_ready;
                        step();
                        cyc++;
                    end
                end
                b_s0_valid = 1'b0;
            end
            begin : prod1
                int cyc = 0;
                for (int i = 0; i < 4000 && cyc < 60000; i++) begin
                    logic acc;
                    b_s1_valid = 1'b0;
                    repeat ($urandom_range(0, 1)) begin step(); cyc++; end
                    b_s1_valid = 1'b1;
                    b_s1_data  = t1[i];
                    acc = 1'b0;
                    while (!acc && cyc < 60000) begin
                        acc = b_s1_ready;
                        step();
                        cyc++;
                    end
                end
                b_s1_valid = 1'b0;
            end
            begin : cons
                int f = 0;
                int cyc = 0;
                while (f < 1000 && cyc < 60000) begin
                    logic        take;
                    logic [31:0] got;
                    b_s2_ready = ($urandom_range(0, 3) != 0);
                    take = b_s2_valid && b_s2_ready;
                    got  = b_s2_data;
                    step();
                    cyc++;
                    if (take) begin
                        chk("rand_sum", got, exp_b[f]);
                        f++;
                    end
                end
                b_s2_ready = 1'b0;
                chk("rand_firings_seen", f, 32'd1000);
            end
        join
        chk("rand_fire_count", b_fire_count, 32'd1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
